// File: rtl/d_e_stage_reg.sv
// Decode/Execute pipeline register with load-use hazard detection.
//
// Captures the decoded instruction from the F/D register each cycle and
// presents it to the forwarding unit and the EX stage. A load followed
// directly by a consumer of its destination produces a single bubble. A taken
// branch resolved in EX also produces a bubble. A busy memory stage freezes
// the register. Two saturating counters record bubbles and flushes for
// performance debug.
//
// Handshake: D_E holds a real instruction exactly when D_E_valid=1. EX
// consumes D_E on every rising edge where M_stall=0. F/D (and the PC) may only
// advance on an edge where stall_F_D=0. Otherwise they hold their contents so
// the same instruction is offered again on the next cycle.
module d_e_stage_reg #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              F_D_valid,
    input  logic [PC_W-1:0]   F_D_pc,
    input  logic [4:0]        F_D_rs1_index,
    input  logic [4:0]        F_D_rs2_index,
    input  logic              F_D_rs1_used,
    input  logic              F_D_rs2_used,
    input  logic [4:0]        F_D_rd_index,
    input  logic [XLEN-1:0]   F_D_rs1_data,
    input  logic [XLEN-1:0]   F_D_rs2_data,
    input  logic [XLEN-1:0]   F_D_imm,
    input  logic [CTRL_W-1:0] F_D_ctrl,
    input  logic              F_D_mem_read,
    input  logic              F_D_reg_write,

    input  logic              E_flush,
    input  logic              M_stall,

    output logic              D_E_valid,
    output logic [PC_W-1:0]   D_E_pc,
    output logic [4:0]        D_E_rs1_index,
    output logic [4:0]        D_E_rs2_index,
    output logic [4:0]        D_E_rd_index,
    output logic [XLEN-1:0]   D_E_rs1_data,
    output logic [XLEN-1:0]   D_E_rs2_data,
    output logic [XLEN-1:0]   D_E_imm,
    output logic [CTRL_W-1:0] D_E_ctrl,
    output logic              D_E_mem_read,
    output logic              D_E_reg_write,

    output logic              stall_F_D,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,

    // Current occupancy state, exported for debug and assertion binding.
    output logic [0:0]        dbg_state
);

    localparam logic [0:0]       ST_EMPTY = 1'b0;
    localparam logic [0:0]       ST_VALID = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0] state_q;
    logic [0:0] state_d;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;

    logic       take_flush;
    logic       take_hold;
    logic       take_bubble;
    logic       take_capture;

    logic [4:0] rs1_gated;
    logic [4:0] rs2_gated;
    logic [4:0] rd_gated;

    // Load-use hazard: the load in D_E writes a real register that F/D reads.
    // This is the only path from the registered D_E fields back into the
    // capture decision.
    always_comb begin
        rs1_hit  = F_D_rs1_used & (F_D_rs1_index == D_E_rd_index);
        rs2_hit  = F_D_rs2_used & (F_D_rs2_index == D_E_rd_index);
        load_use = D_E_valid & D_E_mem_read & (D_E_rd_index != 5'd0)
                 & F_D_valid & (rs1_hit | rs2_hit);
    end

    // Edge action decode, in priority order: flush, memory stall, load-use,
    // capture. Exactly one of the four actions is active, or none of them if
    // F/D presents no instruction. In that case a bubble is loaded.
    always_comb begin
        take_flush   = E_flush;
        take_hold    = ~E_flush & M_stall;
        take_bubble  = ~E_flush & ~M_stall & load_use;
        take_capture = ~E_flush & ~M_stall & ~load_use & F_D_valid;
    end

    // A flush overrides any stall because everything upstream is discarded.
    always_comb begin
        stall_F_D = ~E_flush & (M_stall | load_use);
    end

    // Unused source ports and non-writing destinations are zeroed so that they
    // never match a producer in the forwarding unit or the hazard check.
    always_comb begin
        rs1_gated = F_D_rs1_used  ? F_D_rs1_index : 5'd0;
        rs2_gated = F_D_rs2_used  ? F_D_rs2_index : 5'd0;
        rd_gated  = F_D_reg_write ? F_D_rd_index  : 5'd0;
    end

    // Next occupancy state: hold on stall, VALID on capture, otherwise EMPTY.
    always_comb begin
        state_d = state_q;
        if (take_capture) begin
            state_d = ST_VALID;
        end else if (!take_hold) begin
            state_d = ST_EMPTY;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Field capture. A bubble is the all-zero reset image of every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_E_pc        <= '0;
            D_E_rs1_index <= '0;
            D_E_rs2_index <= '0;
            D_E_rd_index  <= '0;
            D_E_rs1_data  <= '0;
            D_E_rs2_data  <= '0;
            D_E_imm       <= '0;
            D_E_ctrl      <= '0;
            D_E_mem_read  <= 1'b0;
            D_E_reg_write <= 1'b0;
        end else if (take_capture) begin
            D_E_pc        <= F_D_pc;
            D_E_rs1_index <= rs1_gated;
            D_E_rs2_index <= rs2_gated;
            D_E_rd_index  <= rd_gated;
            D_E_rs1_data  <= F_D_rs1_data;
            D_E_rs2_data  <= F_D_rs2_data;
            D_E_imm       <= F_D_imm;
            D_E_ctrl      <= F_D_ctrl;
            D_E_mem_read  <= F_D_mem_read;
            D_E_reg_write <= F_D_reg_write;
        end else if (!take_hold) begin
            D_E_pc        <= '0;
            D_E_rs1_index <= '0;
            D_E_rs2_index <= '0;
            D_E_rd_index  <= '0;
            D_E_rs1_data  <= '0;
            D_E_rs2_data  <= '0;
            D_E_imm       <= '0;
            D_E_ctrl      <= '0;
            D_E_mem_read  <= 1'b0;
            D_E_reg_write <= 1'b0;
        end
    end

    // Load-use bubble counter. It saturates at all-ones and is frozen by a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (take_bubble && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

    // Flush counter. It counts only flushes that kill a real instruction, and it saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (take_flush && state_q == ST_VALID && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign D_E_valid = (state_q == ST_VALID);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_d_e_stage_reg.sv
// Testbench for d_e_stage_reg.
//
// A reference model of the D/E register is advanced by the driver once per
// clock. The driver pushes the expected output image for each cycle into
// exp_q. A monitor pops that image on the falling edge and compares it with
// the DUT outputs.
module tb_d_e_stage_reg;

    localparam int XLEN   = 32;
    localparam int PC_W   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int SW     = 1 + PC_W + 15 + 3 * XLEN + CTRL_W + 2 + 2 * CNT_W + 1;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [4:0]        rs1;
        logic              rs1_used;
        logic [4:0]        rs2;
        logic              rs2_used;
        logic [4:0]        rd;
        logic [XLEN-1:0]   d1;
        logic [XLEN-1:0]   d2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              reg_write;
    } ins_t;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   d1;
        logic [XLEN-1:0]   d2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              reg_write;
    } de_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              F_D_valid;
    logic [PC_W-1:0]   F_D_pc;
    logic [4:0]        F_D_rs1_index;
    logic [4:0]        F_D_rs2_index;
    logic              F_D_rs1_used;
    logic              F_D_rs2_used;
    logic [4:0]        F_D_rd_index;
    logic [XLEN-1:0]   F_D_rs1_data;
    logic [XLEN-1:0]   F_D_rs2_data;
    logic [XLEN-1:0]   F_D_imm;
    logic [CTRL_W-1:0] F_D_ctrl;
    logic              F_D_mem_read;
    logic              F_D_reg_write;
    logic              E_flush;
    logic              M_stall;
    logic              D_E_valid;
    logic [PC_W-1:0]   D_E_pc;
    logic [4:0]        D_E_rs1_index;
    logic [4:0]        D_E_rs2_index;
    logic [4:0]        D_E_rd_index;
    logic [XLEN-1:0]   D_E_rs1_data;
    logic [XLEN-1:0]   D_E_rs2_data;
    logic [XLEN-1:0]   D_E_imm;
    logic [CTRL_W-1:0] D_E_ctrl;
    logic              D_E_mem_read;
    logic              D_E_reg_write;
    logic              stall_F_D;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [0:0]        dbg_state;

    logic [SW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;

    // Reference model state.
    de_t m;
    int  m_bub;
    int  m_flu;

    d_e_stage_reg #(
        .XLEN(XLEN), .PC_W(PC_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .F_D_valid(F_D_valid), .F_D_pc(F_D_pc),
        .F_D_rs1_index(F_D_rs1_index), .F_D_rs2_index(F_D_rs2_index),
        .F_D_rs1_used(F_D_rs1_used), .F_D_rs2_used(F_D_rs2_used),
        .F_D_rd_index(F_D_rd_index),
        .F_D_rs1_data(F_D_rs1_data), .F_D_rs2_data(F_D_rs2_data),
        .F_D_imm(F_D_imm), .F_D_ctrl(F_D_ctrl),
        .F_D_mem_read(F_D_mem_read), .F_D_reg_write(F_D_reg_write),
        .E_flush(E_flush), .M_stall(M_stall),
        .D_E_valid(D_E_valid), .D_E_pc(D_E_pc),
        .D_E_rs1_index(D_E_rs1_index), .D_E_rs2_index(D_E_rs2_index),
        .D_E_rd_index(D_E_rd_index),
        .D_E_rs1_data(D_E_rs1_data), .D_E_rs2_data(D_E_rs2_data),
        .D_E_imm(D_E_imm), .D_E_ctrl(D_E_ctrl),
        .D_E_mem_read(D_E_mem_read), .D_E_reg_write(D_E_reg_write),
        .stall_F_D(stall_F_D), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog that bounds the whole run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit, got=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input int c);
        int v;
        v = (c > CMAX) ? CMAX : c;
        return v[CNT_W-1:0];
    endfunction

    function automatic logic [SW-1:0] dut_image();
        return {D_E_valid, D_E_pc, D_E_rs1_index, D_E_rs2_index, D_E_rd_index,
                D_E_rs1_data, D_E_rs2_data, D_E_imm, D_E_ctrl, D_E_mem_read,
                D_E_reg_write, bubble_cnt, flush_cnt, stall_F_D};
    endfunction

    function automatic logic [SW-1:0] model_image(input logic stall);
        return {m, sat(m_bub), sat(m_flu), stall};
    endfunction

    // The function returns an instruction that reads rs1 and rs2 (each only if used) and
    // writes rd. The data fields are random.
    function automatic ins_t mk(input logic [PC_W-1:0] pc, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr);
        ins_t i;
        i.valid     = 1'b1;
        i.pc        = pc;
        i.rs1       = rs1;
        i.rs1_used  = u1;
        i.rs2       = rs2;
        i.rs2_used  = u2;
        i.rd        = rd;
        i.d1        = $urandom;
        i.d2        = $urandom;
        i.imm       = $urandom;
        i.ctrl      = CTRL_W'($urandom);
        i.mem_read  = mr;
        i.reg_write = rw;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i = mk({PC_W'($urandom_range(0, 1023)), 2'b00} , 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 2) == 0));
        i.valid = ($urandom_range(0, 7) != 0);
        return i;
    endfunction

    task automatic idle_inputs();
        F_D_valid = 0; F_D_pc = '0; F_D_rs1_index = '0; F_D_rs2_index = '0;
        F_D_rs1_used = 0; F_D_rs2_used = 0; F_D_rd_index = '0;
        F_D_rs1_data = '0; F_D_rs2_data = '0; F_D_imm = '0; F_D_ctrl = '0;
        F_D_mem_read = 0; F_D_reg_write = 0; E_flush = 0; M_stall = 0;
    endtask

    task automatic model_reset();
        m     = '0;
        m_bub = 0;
        m_flu = 0;
    endtask

    // The task drives one cycle of inputs. It queues the expected image for this cycle,
    // and then it moves the model forward to its contents after the next rising edge.
    task automatic step(input ins_t i, input logic fl, input logic ms);
        logic hz;
        logic stall;
        @(posedge clk);
        #1;
        F_D_valid = i.valid; F_D_pc = i.pc;
        F_D_rs1_index = i.rs1; F_D_rs2_index = i.rs2;
        F_D_rs1_used = i.rs1_used; F_D_rs2_used = i.rs2_used;
        F_D_rd_index = i.rd; F_D_rs1_data = i.d1; F_D_rs2_data = i.d2;
        F_D_imm = i.imm; F_D_ctrl = i.ctrl;
        F_D_mem_read = i.mem_read; F_D_reg_write = i.reg_write;
        E_flush = fl; M_stall = ms;

        // A load waiting in D_E that writes a real register read by the new instruction.
        hz = m.valid && m.mem_read && m.rd != 0 && i.valid &&
             ((i.rs1_used && i.rs1 == m.rd) || (i.rs2_used && i.rs2 == m.rd));
        stall = !fl && (ms || hz);
        exp_q.push_back(model_image(stall));

        if (fl) begin
            if (m.valid) m_flu++;
            m = '0;
        end else if (ms) begin
            m = m;
        end else if (hz) begin
            m_bub++;
            m = '0;
        end else if (i.valid) begin
            m.valid     = 1'b1;
            m.pc        = i.pc;
            m.rs1       = i.rs1_used ? i.rs1 : 5'd0;
            m.rs2       = i.rs2_used ? i.rs2 : 5'd0;
            m.rd        = i.reg_write ? i.rd : 5'd0;
            m.d1        = i.d1;
            m.d2        = i.d2;
            m.imm       = i.imm;
            m.ctrl      = i.ctrl;
            m.mem_read  = i.mem_read;
            m.reg_write = i.reg_write;
        end else begin
            m = '0;
        end
    endtask

    // Monitor: compare each presented cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            check("cycle_image", dut_image(), exp_q.pop_front());
        end
    end

    ins_t idle_i;
    ins_t a;
    ins_t b;

    initial begin
        idle_i = '0;
        model_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_initial", dut_image(), '0);
        check("reset_state", SW'(dbg_state), '0);
        rst = 1'b0;

        // Load followed by a dependent add: one bubble, then the add is captured.
        a = mk(32'h100, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
        b = mk(32'h104, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        step(a, 0, 0);
        step(b, 0, 0);
        step(b, 0, 0);
        step(idle_i, 0, 0);
        step(idle_i, 0, 0);

        // Load of x0, then a reader of x0: there is no hazard.
        step(mk(32'h200, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1), 0, 0);
        step(mk(32'h204, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0), 0, 0);
        // Load of x5, then rs2=5 but rs2 is not used: there is no hazard.
        step(mk(32'h208, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1), 0, 0);
        step(mk(32'h20c, 5'd3, 1, 5'd5, 0, 5'd4, 1, 0), 0, 0);
        step(idle_i, 0, 0);

        // A load-use hazard together with a flush: the flush wins.
        step(mk(32'h300, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1), 0, 0);
        step(mk(32'h304, 5'd7, 1, 5'd2, 1, 5'd8, 1, 0), 1, 0);
        step(idle_i, 0, 0);

        // Memory stall for three cycles while D_E holds PC 0x40.
        a = mk(32'h40, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        b = mk(32'h44, 5'd4, 1, 5'd5, 1, 5'd6, 1, 0);
        step(a, 0, 0);
        repeat (3) step(b, 0, 1);
        step(b, 0, 0);
        step(idle_i, 0, 0);

        // Randomised traffic that mixes flushes and stalls.
        for (int n = 0; n < 1500; n++) begin
            step(rand_ins(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end

        // Drive the bubble counter past saturation with a load that feeds itself.
        a = mk(32'h500, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1);
        for (int n = 0; n < 600; n++) step(a, 0, 0);
        step(idle_i, 0, 0);
        @(negedge clk);
        check("bubble_saturated", SW'(bubble_cnt), SW'(CMAX));

        // Drive the flush counter past saturation.
        a = mk(32'h600, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        for (int n = 0; n < 300; n++) begin
            step(a, 0, 0);
            step(a, 1, 0);
        end
        step(idle_i, 0, 0);
        @(negedge clk);
        check("flush_saturated", SW'(flush_cnt), SW'(CMAX));

        // Reset arrives while a load-use stall is pending. Everything clears at
        // once and no stall remains.
        step(mk(32'h700, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1), 0, 0);
        step(mk(32'h704, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0), 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_mid_stall", dut_image(), '0);
        check("reset_async_state", SW'(dbg_state), '0);
        @(negedge clk);
        idle_inputs();
        model_reset();
        rst = 1'b0;

        for (int n = 0; n < 200; n++) begin
            step(rand_ins(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", SW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
